matmul_mem_master: RTL

- Initiator side of the matrix memory interface: reads operand matrices A and B from the shared matrix memory, computes C = A x B, and writes C back.
- Issues one read per access and one write per result element, through a single-port read/write request interface.
- Sits between the top-level control (start/done) and the matrix memory; it is the only driver of the memory address and enable lines during a run.

---
 rtl/matmul_mem_master.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/matmul_mem_master.sv
// Matrix-memory initiator: reads A and B, computes C = A x B, writes C back row-major.
// Optional build macro MATMUL_SATURATE_EN clamps C to 2^SIZE-1 and adds a sticky sat_flag.
module matmul_mem_master #(
    parameter int N      = 2,
    parameter int SIZE   = 8,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] A_BASE = 32'd0,
    parameter logic [ADDR_W-1:0] B_BASE = 32'd4,
    parameter logic [ADDR_W-1:0] C_BASE = 32'd8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              read,
    output logic [ADDR_W-1:0] read_address,
    input  logic [SIZE-1:0]   read_data,
    output logic              write,
    output logic [ADDR_W-1:0] write_address,
    output logic [SIZE-1:0]   write_value
`ifdef MATMUL_SATURATE_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * SIZE + $clog2(N) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        MAC  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     i_r;
    logic [CW-1:0]     j_r;
    logic [CW-1:0]     k_r;
    logic [ACC_W-1:0]  acc_r;
    logic [SIZE-1:0]   a_lat_r;
    logic              done_r;
    logic              last_k_s;
    logic              last_elem_s;
    logic              acc_big_s;
    logic [SIZE-1:0]   wr_val_s;

    // Narrow the accumulator to an element; clamp when saturation is requested.
    function automatic logic [SIZE-1:0] narrow_acc(input logic [ACC_W-1:0] acc, input logic clamp);
        logic [SIZE-1:0] res;
        if (clamp && ((acc >> SIZE) != ACC_W'(0))) begin
            res = {SIZE{1'b1}};
        end else begin
            res = acc[SIZE-1:0];
        end
        return res;
    endfunction

    assign last_k_s    = (k_r == CW'(N - 1));
    assign last_elem_s = (i_r == CW'(N - 1)) && (j_r == CW'(N - 1));
    assign acc_big_s   = ((acc_r >> SIZE) != ACC_W'(0));

`ifdef MATMUL_SATURATE_EN
    assign wr_val_s = narrow_acc(acc_r, 1'b1);
`else
    assign wr_val_s = narrow_acc(acc_r, 1'b0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RD_A;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_A: state_nxt_s = RD_B;
            RD_B: state_nxt_s = MAC;
            MAC: begin
                if (last_k_s) begin
                    state_nxt_s = WR;
                end else begin
                    state_nxt_s = RD_A;
                end
            end
            WR: begin
                if (last_elem_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RD_A;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Index counters, operand latch and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r     <= CW'(0);
            j_r     <= CW'(0);
            k_r     <= CW'(0);
            acc_r   <= ACC_W'(0);
            a_lat_r <= SIZE'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        i_r   <= CW'(0);
                        j_r   <= CW'(0);
                        k_r   <= CW'(0);
                        acc_r <= ACC_W'(0);
                    end
                end
                RD_B: a_lat_r <= read_data;
                MAC: begin
                    acc_r <= acc_r + ACC_W'(a_lat_r) * ACC_W'(read_data);
                    k_r   <= last_k_s ? CW'(0) : k_r + CW'(1);
                end
                WR: begin
                    acc_r <= ACC_W'(0);
                    if (!last_elem_s) begin
                        if (j_r == CW'(N - 1)) begin
                            j_r <= CW'(0);
                            i_r <= i_r + CW'(1);
                        end else begin
                            j_r <= j_r + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completion pulse, registered off the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == DONE);
        end
    end

    assign done = done_r;

`ifdef MATMUL_SATURATE_EN
    logic sat_r;

    // Sticky saturation indicator, cleared when a run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            sat_r <= 1'b0;
        end else if ((state_r == WR) && acc_big_s) begin
            sat_r <= 1'b1;
        end else begin
            sat_r <= sat_r;
        end
    end

    assign sat_flag = sat_r;
`else
    logic unused_s;
    assign unused_s = acc_big_s;
`endif

    // Memory request decode; driven only from registered state and counters.
    always_comb begin
        busy          = (state_r != IDLE);
        read          = 1'b0;
        read_address  = ADDR_W'(0);
        write         = 1'b0;
        write_address = ADDR_W'(0);
        write_value   = SIZE'(0);
        case (state_r)
            RD_A: begin
                read         = 1'b1;
                read_address = A_BASE + ADDR_W'(i_r) * ADDR_W'(N) + ADDR_W'(k_r);
            end
            RD_B: begin
                read         = 1'b1;
                read_address = B_BASE + ADDR_W'(k_r) * ADDR_W'(N) + ADDR_W'(j_r);
            end
            WR: begin
                write         = 1'b1;
                write_address = C_BASE + ADDR_W'(i_r) * ADDR_W'(N) + ADDR_W'(j_r);
                write_value   = wr_val_s;
            end
            default: begin
                read  = 1'b0;
                write = 1'b0;
            end
        endcase
    end

endmodule
